bcd_timer: RTL and testbench

Parametrised MM:SS BCD timer for the board-level clock display path. Counts up or down in seconds, with run/pause, preset load, clear, display hold (lap), a fast-step mode and a countdown expiry flag. Sits between the 50 MHz board clock and the four 7-segment digits, replacing the chain of per-digit dividers with one prescaler and one BCD counter.

---
 rtl/bcd_timer_pkg.sv | 44 ++++
 rtl/bcd_timer_if.sv | 33 +++
 rtl/bcd_timer_seg7_decode.sv | 48 ++++
 rtl/bcd_timer.sv | 125 ++++++++++++
 tb/tb_bcd_timer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared BCD time type, digit limits and digit step helpers
package bcd_timer_pkg;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    localparam logic [3:0] MAX_UNITS = 4'd9;
    localparam logic [3:0] MAX_TENS  = 4'd5;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Result layout is {carry, next}; a digit at or past its limit rolls to zero.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
        if (d >= max) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    // Result layout is {borrow, next}; zero rolls back to the digit limit.
    function automatic logic [4:0] bcd_dec(input logic [3:0] d, input logic [3:0] max);
        if (d == 4'd0) begin
            return {1'b1, max};
        end
        return {1'b0, d - 4'd1};
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    function automatic bcd_time_t bcd_sanitize(input logic [15:0] p);
        bcd_time_t t;
        t.m1 = clamp_digit(p[15:12], MAX_TENS);
        t.m0 = clamp_digit(p[11:8],  MAX_UNITS);
        t.s1 = clamp_digit(p[7:4],   MAX_TENS);
        t.s0 = clamp_digit(p[3:0],   MAX_UNITS);
        return t;
    endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// rtl/bcd_timer_if.sv - control/display bundle of the timer; HEX only with BCD_TIMER_SEG_EN
interface bcd_timer_if;
    logic        clear;
    logic        load;
    logic [15:0] preset;
    logic        run;
    logic        dir;
    logic        fast;
    logic        hold;
    logic [15:0] digits;
    logic        tick;
    logic        wrap;
    logic        expired;
`ifdef BCD_TIMER_SEG_EN
    logic [27:0] hex;
`endif

    modport master (
        output clear, load, preset, run, dir, fast, hold,
        input  digits, tick, wrap, expired
`ifdef BCD_TIMER_SEG_EN
        , input hex
`endif
    );

    modport slave (
        input  clear, load, preset, run, dir, fast, hold,
        output digits, tick, wrap, expired
`ifdef BCD_TIMER_SEG_EN
        , output hex
`endif
    );
endinterface

// File: rtl/bcd_timer_seg7_decode.sv
// rtl/bcd_timer_seg7_decode.sv - registered BCD/hex to active-low 7-segment decoder
module seg7_decode
    import bcd_timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_d;
    logic [6:0] seg_q;

    // Segment order is {g,f,e,d,c,b,a}; 1 = segment off.
    always_comb begin
        seg_d = SEG_BLANK;
        case (bcd_i)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            4'hF: seg_d = 7'b0001110;
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seg_q <= 7'b1000000;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - MM:SS BCD up/down timer with prescaler; BCD_TIMER_SEG_EN adds HEX decoders
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int SEC_DIV     = 50000000,
    parameter int FAST_FACTOR = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    bcd_timer_if.slave  bus
);

    localparam int FAST_DIV = ((SEC_DIV / FAST_FACTOR) >= 1) ? (SEC_DIV / FAST_FACTOR) : 1;
    localparam int PS_W     = $clog2(SEC_DIV);
    localparam logic [PS_W-1:0] LIM_SLOW = PS_W'(SEC_DIV - 1);
    localparam logic [PS_W-1:0] LIM_FAST = PS_W'(FAST_DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    bcd_time_t       cnt_q, cnt_d;
    bcd_time_t       disp_q, disp_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic            exp_q, exp_d;

    logic [PS_W-1:0] limit;
    logic            step_due;
    bcd_time_t       up_val;
    bcd_time_t       dn_val;
    logic            up_wrap;
    logic            cnt_zero;

    logic [4:0] u0, u1, u2, u3;
    logic [4:0] b0, b1, b2, b3;

    // ">=" rather than "==" so a switch to the short period mid-count still steps.
    assign limit    = bus.fast ? LIM_FAST : LIM_SLOW;
    assign step_due = (ps_q >= limit);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        u0 = bcd_inc(cnt_q.s0, MAX_UNITS);
        u1 = u0[4] ? bcd_inc(cnt_q.s1, MAX_TENS)  : {1'b0, cnt_q.s1};
        u2 = u1[4] ? bcd_inc(cnt_q.m0, MAX_UNITS) : {1'b0, cnt_q.m0};
        u3 = u2[4] ? bcd_inc(cnt_q.m1, MAX_TENS)  : {1'b0, cnt_q.m1};
        up_val  = '{m1: u3[3:0], m0: u2[3:0], s1: u1[3:0], s0: u0[3:0]};
        up_wrap = u3[4];
    end

    always_comb begin
        b0 = bcd_dec(cnt_q.s0, MAX_UNITS);
        b1 = b0[4] ? bcd_dec(cnt_q.s1, MAX_TENS)  : {1'b0, cnt_q.s1};
        b2 = b1[4] ? bcd_dec(cnt_q.m0, MAX_UNITS) : {1'b0, cnt_q.m0};
        b3 = b2[4] ? bcd_dec(cnt_q.m1, MAX_TENS)  : {1'b0, cnt_q.m1};
        dn_val = '{m1: b3[3:0], m0: b2[3:0], s1: b1[3:0], s0: b0[3:0]};
    end

    always_comb begin
        ps_d   = ps_q;
        cnt_d  = cnt_q;
        exp_d  = exp_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        disp_d = bus.hold ? disp_q : cnt_q;

        if (bus.clear) begin
            ps_d  = '0;
            cnt_d = '0;
            exp_d = 1'b0;
        end else if (bus.load) begin
            ps_d  = '0;
            cnt_d = bcd_sanitize(bus.preset);
            exp_d = 1'b0;
        end else if (bus.run) begin
            if (step_due) begin
                ps_d = '0;
                if (bus.dir) begin
                    cnt_d  = up_val;
                    tick_d = 1'b1;
                    wrap_d = up_wrap;
                    exp_d  = 1'b0;
                end else if (!cnt_zero) begin
                    // A countdown parked at 00:00 swallows further steps silently.
                    cnt_d  = dn_val;
                    tick_d = 1'b1;
                    if (dn_val == '0) begin
                        exp_d = 1'b1;
                    end
                end
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ps_q   <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            exp_q  <= exp_d;
        end
    end

    assign bus.digits  = disp_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.expired = exp_q;

`ifdef BCD_TIMER_SEG_EN
    seg7_decode u_hex0 (.clk_i(clk_i), .rst_i(rst_i), .bcd_i(disp_q.s0), .seg_o(bus.hex[6:0]));
    seg7_decode u_hex1 (.clk_i(clk_i), .rst_i(rst_i), .bcd_i(disp_q.s1), .seg_o(bus.hex[13:7]));
    seg7_decode u_hex2 (.clk_i(clk_i), .rst_i(rst_i), .bcd_i(disp_q.m0), .seg_o(bus.hex[20:14]));
    seg7_decode u_hex3 (.clk_i(clk_i), .rst_i(rst_i), .bcd_i(disp_q.m1), .seg_o(bus.hex[27:21]));
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// tb/tb_bcd_timer.sv - scoreboard bench: seconds-based reference model vs bcd_timer
module tb_bcd_timer;

    localparam int SEC_DIV     = 10;
    localparam int FAST_FACTOR = 5;

    typedef struct {
        logic [15:0] digits;
        logic        tick;
        logic        wrap;
        logic        expired;
        logic [27:0] hex;
    } exp_t;

    typedef struct {
        logic [15:0] cnt;
        logic        wrap;
        logic        expired;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_timer_if bus ();

    bcd_timer #(.SEC_DIV(SEC_DIV), .FAST_FACTOR(FAST_FACTOR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t  cyc_q[$];
    step_t step_q[$];

    // Reference state: the count is plain seconds 0..3599.
    int          t_m   = 0;
    int          ps_m  = 0;
    bit          exp_m = 1'b0;
    logic [15:0] disp_m = '0;
    logic [27:0] hex_m  = '0;

    function automatic logic [15:0] to_bcd(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int lim(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic int preset_secs(input logic [15:0] p);
        int mins;
        int secs;
        mins = lim(int'(p[15:12]), 5) * 10 + lim(int'(p[11:8]), 9);
        secs = lim(int'(p[7:4]), 5) * 10 + lim(int'(p[3:0]), 9);
        return mins * 60 + secs;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[d];
    endfunction

    function automatic logic [27:0] hex_of(input logic [15:0] v);
        return {glyph(v[15:12]), glyph(v[11:8]), glyph(v[7:4]), glyph(v[3:0])};
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    always @(posedge clk) begin
        int   limit;
        bit   tick_m;
        bit   wrap_m;
        exp_t e;
        step_t s;
        limit  = bus.fast ? ((SEC_DIV / FAST_FACTOR) < 1 ? 1 : SEC_DIV / FAST_FACTOR) - 1
                          : SEC_DIV - 1;
        tick_m = 1'b0;
        wrap_m = 1'b0;
        hex_m  = hex_of(disp_m);
        if (!bus.hold) disp_m = to_bcd(t_m);
        if (rst) begin
            t_m = 0; ps_m = 0; exp_m = 1'b0; disp_m = '0; hex_m = hex_of(16'h0000);
        end else if (bus.clear) begin
            t_m = 0; ps_m = 0; exp_m = 1'b0;
        end else if (bus.load) begin
            t_m = preset_secs(bus.preset); ps_m = 0; exp_m = 1'b0;
        end else if (bus.run) begin
            if (ps_m >= limit) begin
                ps_m = 0;
                if (bus.dir) begin
                    tick_m = 1'b1;
                    wrap_m = (t_m == 3599);
                    t_m    = (t_m + 1) % 3600;
                    exp_m  = 1'b0;
                end else if (t_m != 0) begin
                    tick_m = 1'b1;
                    t_m    = t_m - 1;
                    if (t_m == 0) exp_m = 1'b1;
                end
            end else begin
                ps_m++;
            end
        end
        e.digits = disp_m; e.tick = tick_m; e.wrap = wrap_m; e.expired = exp_m; e.hex = hex_m;
        cyc_q.push_back(e);
        if (tick_m) begin
            s.cnt = to_bcd(t_m); s.wrap = wrap_m; s.expired = exp_m;
            step_q.push_back(s);
        end
    end

    // Per-cycle outputs are checked every cycle; each TICK also retires one step record.
    always @(negedge clk) begin
        exp_t  e;
        step_t s;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("digits",  28'(bus.digits),  28'(e.digits));
            check("tick",    28'(bus.tick),    28'(e.tick));
            check("wrap",    28'(bus.wrap),    28'(e.wrap));
            check("expired", 28'(bus.expired), 28'(e.expired));
`ifdef BCD_TIMER_SEG_EN
            check("hex",     bus.hex,          e.hex);
`endif
        end
        if (bus.tick === 1'b1) begin
            if (step_q.size() == 0) begin
                check("unexpected_tick", 28'(1), 28'(0));
            end else begin
                s = step_q.pop_front();
                check("step_wrap",    28'(bus.wrap),    28'(s.wrap));
                check("step_expired", 28'(bus.expired), 28'(s.expired));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ps(input int target);
        for (int i = 0; i < 50 && ps_m != target; i++) @(negedge clk);
        check("wait_ps_timeout", 28'(ps_m), 28'(target));
    endtask

    task automatic do_load(input logic [15:0] p);
        bus.preset = p;
        bus.load   = 1'b1;
        cyc(1);
        bus.load   = 1'b0;
    endtask

    initial begin
        logic [15:0] picks [4];
        picks = '{16'h5959, 16'h0001, 16'h5958, 16'h0000};
        bus.clear = 1'b0; bus.load = 1'b0; bus.preset = '0;
        bus.run = 1'b0; bus.dir = 1'b1; bus.fast = 1'b0; bus.hold = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        bus.run = 1'b1;
        cyc(35);

        do_load(16'h5958);
        cyc(25);

        bus.dir = 1'b0;
        do_load(16'h0002);
        cyc(45);
        do_load(16'h0010);
        cyc(3);

        bus.dir = 1'b1;
        do_load(16'h0000);
        bus.fast = 1'b1;
        cyc(10);
        bus.fast = 1'b0;
        wait_ps(7);
        bus.fast = 1'b1;
        cyc(8);
        bus.fast = 1'b0;

        do_load(16'h0003);
        cyc(2);
        bus.hold = 1'b1;
        cyc(40);
        bus.hold = 1'b0;
        cyc(3);

        do_load(16'hAF7C);
        cyc(4);
        wait_ps(9);
        bus.clear = 1'b1;
        cyc(2);
        bus.clear = 1'b0;
        cyc(12);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            bus.clear  = (r < 2);
            bus.load   = (r >= 2 && r < 5);
            bus.preset = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 3)]
                                                     : 16'($urandom);
            bus.run    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) bus.dir  = ~bus.dir;
            if ($urandom_range(0, 29) == 0) bus.fast = ~bus.fast;
            if ($urandom_range(0, 39) == 0) bus.hold = ~bus.hold;
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end

        rst = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.run = 1'b0;
        cyc(3);
        check("steps_left", 28'(step_q.size()), 28'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
